// File: rtl/max_pool_2x2_if.sv
// ============================================================================
// max_pool_2x2_if : pixel-stream bundle between a producer and the 2x2 pooler
// Revision: 1.0
// ============================================================================
`default_nettype none

interface max_pool_2x2_if #(
  parameter int DATA_W = 12
);
  logic                     clear;
  logic                     valid_in;
  logic signed [DATA_W-1:0] data_in;
  logic                     valid_out;
  logic signed [DATA_W-1:0] data_out;
  logic                     frame_done;

  modport master (
    output clear, valid_in, data_in,
    input  valid_out, data_out, frame_done
  );

  modport slave (
    input  clear, valid_in, data_in,
    output valid_out, data_out, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/max_pool_2x2.sv
// ============================================================================
// max_pool_2x2 : streaming 2x2 / stride-2 signed max pooling over a raster frame
// Revision: 1.0
// ============================================================================
`default_nettype none

module max_pool_2x2 #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  max_pool_2x2_if.slave  bus
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int BUF_N  = IMG_W / 2;
  localparam int BUF_AW = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  logic        [COL_W-1:0]  col;
  logic        [ROW_W-1:0]  row;
  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] row_buf [BUF_N];

  logic        [BUF_AW-1:0] buf_idx;
  logic signed [DATA_W-1:0] above;
  logic signed [DATA_W-1:0] h_max;
  logic signed [DATA_W-1:0] win_max;
  logic                     last_col;
  logic                     last_row;
  logic                     take;

  assign take     = bus.valid_in && !bus.clear;
  assign buf_idx  = BUF_AW'(col >> 1);
  assign above    = row_buf[buf_idx];
  assign h_max    = (pair  > bus.data_in) ? pair  : bus.data_in;
  assign win_max  = (h_max > above)       ? h_max : above;
  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_row = (row == ROW_W'(IMG_H - 1));

  // Row buffer is always written in an even row before the odd row reads it,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (take && col[0] && !row[0]) begin
      row_buf[buf_idx] <= h_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      pair           <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.data_out   <= '0;
    end else begin
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.clear) begin
        col  <= '0;
        row  <= '0;
        pair <= '0;
      end else if (bus.valid_in) begin
        if (!col[0]) begin
          pair <= bus.data_in;
        end else if (row[0]) begin
          bus.data_out   <= win_max;
          bus.valid_out  <= 1'b1;
          bus.frame_done <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
// ============================================================================
// tb_max_pool_2x2 : directed 4x4 frames, scoreboard checks value, cycle and frame_done
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_max_pool_2x2;

  localparam int DW = 12;

  typedef logic signed [DW-1:0] pix_t;
  typedef struct {
    pix_t data;
    bit   fd;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  pix_t last_data = '0;
  exp_t exp_q[$];

  max_pool_2x2_if #(.DATA_W(DW)) bus ();

  max_pool_2x2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the head of the queue, including
  // the cycle it was due; idle cycles must hold data_out and keep frame_done low.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = '0;
    end else if (bus.valid_out) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got data=%0d fd=%0b at cyc %0d, required no output",
                 bus.data_out, bus.frame_done, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.data_out !== e.data || bus.frame_done !== e.fd || cyc != e.cyc) begin
          n_err++;
          $display("FAIL pooled_output: got data=%0d fd=%0b cyc=%0d, required data=%0d fd=%0b cyc=%0d",
                   bus.data_out, bus.frame_done, cyc, e.data, e.fd, e.cyc);
        end
      end
      last_data = bus.data_out;
    end else begin
      n_cmp++;
      if (bus.frame_done !== 1'b0 || bus.data_out !== last_data) begin
        n_err++;
        $display("FAIL idle_hold: got data=%0d fd=%0b at cyc %0d, required data=%0d fd=0",
                 bus.data_out, bus.frame_done, cyc, last_data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.frame_done !== 1'b0 || bus.data_out !== '0) begin
      n_err++;
      $display("FAIL %s: got valid=%0b fd=%0b data=%0d, required 0/0/0",
               tag, bus.valid_out, bus.frame_done, bus.data_out);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the capturing edge.
  task automatic send(input pix_t v, input bit chk, input pix_t e, input bit fd, input bit clr);
    exp_t x;
    bus.valid_in = 1'b1;
    bus.data_in  = v;
    bus.clear    = clr;
    if (chk) begin
      x.data = e;
      x.fd   = fd;
      x.cyc  = cyc + 1;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends pixels 0..n-1 of a frame; windows complete on pixels 5, 7, 13, 15.
  task automatic send_frame(input pix_t px[16], input pix_t ex[4], input int n,
                            input int gap, input int clr_at, input bit expect_out);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      bit chk;
      chk = expect_out && (i == 5 || i == 7 || i == 13 || i == 15) && (i != clr_at);
      send(px[i], chk, ex[k], (i == 15), (i == clr_at));
      if (i == 5 || i == 7 || i == 13 || i == 15) k++;
      if (gap > 0) idle(gap);
    end
  endtask

  pix_t ramp[16], neg[16], sat[16];
  pix_t ex_ramp[4], ex_neg[4], ex_sat[4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i] = pix_t'(i);
      neg[i]  = pix_t'(-1 - i);
      sat[i]  = (i == 0) ? -12'sd2048 : 12'sd2047;
    end
    ex_ramp = '{12'sd5, 12'sd7, 12'sd13, 12'sd15};
    ex_neg  = '{-12'sd1, -12'sd3, -12'sd9, -12'sd11};
    ex_sat  = '{12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047};

    rst_n        = 1'b0;
    bus.clear    = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    idle(2);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    idle(1);

    send_frame(ramp, ex_ramp, 16, 0, -1, 1'b1);
    idle(2);
    send_frame(neg, ex_neg, 16, 0, -1, 1'b1);
    idle(2);
    send_frame(ramp, ex_ramp, 16, 1, -1, 1'b1);
    idle(2);
    send_frame(ramp, ex_ramp, 16, 0, -1, 1'b1);
    send_frame(sat, ex_sat, 16, 0, -1, 1'b1);
    idle(2);

    // Reset lands right after pixel 5's edge: its pulse must never be seen.
    send_frame(ramp, ex_ramp, 6, 0, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_midframe");
    idle(1);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    send_frame(ramp, ex_ramp, 16, 0, -1, 1'b1);
    idle(2);

    send_frame(ramp, ex_ramp, 10, 0, 9, 1'b1);
    send_frame(ramp, ex_ramp, 16, 0, -1, 1'b1);

    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_outputs: got %0d still pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 Parameter DATA_W, default 12: signed sample width.
REQ-002 Parameter IMG_W, default 24: input feature-map width in pixels; SHALL be even and >= 2.
REQ-003 Parameter IMG_H, default 24: input feature-map height in rows; SHALL be even and >= 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous frame restart, active-high.
REQ-007 valid_in  input  1  data_in carries a pixel this cycle.
REQ-008 data_in  input  DATA_W  signed pixel, raster order (row-major, column 0 first).
REQ-009 valid_out  output  1  data_out carries a pooled pixel this cycle (one-cycle pulse).
REQ-010 data_out  output  DATA_W  signed 2x2 maximum.
REQ-011 frame_done  output  1  one-cycle pulse with the last pooled pixel of a frame.

Function
REQ-012 col counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL advance only on cycles with valid_in=1; idle cycles (bubbles) SHALL not change any state except clearing the output pulses.
REQ-013 Even column: the pixel SHALL be held in a pair register.
REQ-014 Odd column: pair max h = max(pair register, data_in), signed comparison; ties return the equal value.
REQ-015 Even row, odd column: h SHALL be written to row buffer entry col/2 (IMG_W/2 entries x DATA_W); no output.
REQ-016 Odd row, odd column: data_out SHALL be registered as max(h, row buffer[col/2]), with valid_out=1 on the next clock edge (latency 1 cycle from the 4th pixel of the window).
REQ-017 Output order SHALL be raster order of the pooled (IMG_W/2 x IMG_H/2) map.
REQ-018 valid_out SHALL be 0 on every cycle not described in REQ-016; data_out SHALL hold its last value when valid_out=0.
REQ-019 frame_done SHALL assert together with valid_out for the pooled pixel produced from input pixel (IMG_H-1, IMG_W-1).
REQ-020 After input pixel (IMG_H-1, IMG_W-1), col and row SHALL wrap to 0; the next valid_in begins a new frame with no dead cycle.
REQ-021 Back-to-back valid_in at full rate (one pixel per cycle) SHALL be sustained indefinitely.
REQ-022 clear=1 SHALL zero col, row and the pair register on the next edge; a valid_in in the same cycle SHALL be dropped (clear wins); a pending valid_out from the previous cycle's pixel SHALL still be issued.
REQ-023 Row buffer contents SHALL not require clearing; each entry is written in the even row before being read in the odd row.
REQ-024 Full signed range SHALL compare correctly (e.g. -2048 < -1 < 0 < 2047 at DATA_W=12); no saturation or widening.

Reset
REQ-025 With rst_n=0: valid_out=0, frame_done=0, data_out=0, col=0, row=0, pair register=0, asynchronously.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first valid_in after release SHALL be pixel (0,0).
REQ-027 Row buffer need not be reset.

Verification
REQ-028 IMG_W=IMG_H=4, input values 0..15 in raster order at full rate -> outputs 5, 7, 13, 15, each one cycle after pixel 5, 7, 13, 15; frame_done with 15.
REQ-029 Same frame with all values negative (-1 minus index, i.e. -1..-16) -> outputs -1, -3, -9, -11; verifies signed compare.
REQ-030 Same frame with valid_in toggling 1,0 each cycle -> identical outputs, each 1 cycle after its 4th window pixel; no outputs on bubble-induced extra cycles.
REQ-031 Two 4x4 frames back-to-back, second frame all 2047 except pixel (0,0)=-2048 -> second frame outputs 2047 x4, frame_done twice.
REQ-032 rst_n pulsed low after 6 pixels, then full frame 0..15 -> outputs 5, 7, 13, 15 only; no stale output.
REQ-033 clear asserted together with pixel 9 of a frame, then full frame 0..15 -> pixel 9 dropped, outputs from the earlier rows (5, 7) retained, new frame outputs 5, 7, 13, 15.
